// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample, bit-boundary and bit-centre ticks from a shadowed divisor.
// Define BAUD_GEN_FRAC_EN to build the fractional accumulator; otherwise every period is the integer divisor.
module baud_gen_frac #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OSR      = 16,
    parameter int DIV_RST  = 27,
    parameter int FRAC_RST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              div_pending
);
    localparam int OS_W = $clog2(OSR);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2 - 1);

    logic [DIV_W:0]   cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [DIV_W-1:0] act_int_q, act_int_d;
    logic [DIV_W-1:0] sh_int_q, sh_int_d;
    logic             pend_q, pend_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic [DIV_W:0]   div_eff;
    logic [DIV_W:0]   period;
    logic             carry;
    logic             tc;
    logic             last_os;
    logic             apply;
    logic             pend_any;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic [FRAC_W-1:0] acc_sum;

    // Carry out of the accumulator stretches the current period by one clock.
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, act_frac_q};
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^{div_frac, FRAC_W'(FRAC_RST)};
`endif

    // Divisors below 2 clamp to 2.
    assign div_eff = (act_int_q[DIV_W-1:1] == '0) ? {{(DIV_W-1){1'b0}}, 2'd2} : {1'b0, act_int_q};
    assign period  = div_eff + {{DIV_W{1'b0}}, carry};
    // >= guards against an en=0 divisor change landing below the current count.
    assign tc      = (cnt_q >= period - 1'b1);
    assign last_os = (os_cnt_q == OS_LAST);

    always_comb begin
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        act_int_d  = act_int_q;
        sh_int_d   = div_load ? div_int : sh_int_q;
        pend_any   = div_load | pend_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        apply      = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
        acc_d      = acc_q;
        act_frac_d = act_frac_q;
        sh_frac_d  = div_load ? div_frac : sh_frac_q;
`endif
        if (en) begin
            if (resync) begin
                cnt_d    = '0;
                os_cnt_d = '0;
                apply    = pend_any;
`ifdef BAUD_GEN_FRAC_EN
                acc_d    = '0;
`endif
            end else if (tc) begin
                cnt_d      = '0;
                os_tick_d  = 1'b1;
                bit_tick_d = last_os;
                mid_tick_d = (os_cnt_q == OS_MID);
                os_cnt_d   = last_os ? '0 : os_cnt_q + 1'b1;
                apply      = pend_any & last_os;
`ifdef BAUD_GEN_FRAC_EN
                acc_d      = acc_sum;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            apply = pend_any;
        end
        pend_d = pend_any & ~apply;
        if (apply) begin
            act_int_d  = sh_int_d;
`ifdef BAUD_GEN_FRAC_EN
            act_frac_d = sh_frac_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            act_int_q  <= DIV_W'(DIV_RST);
            sh_int_q   <= DIV_W'(DIV_RST);
            pend_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            acc_q      <= '0;
            act_frac_q <= FRAC_W'(FRAC_RST);
            sh_frac_q  <= FRAC_W'(FRAC_RST);
`endif
        end else begin
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            act_int_q  <= act_int_d;
            sh_int_q   <= sh_int_d;
            pend_q     <= pend_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
`ifdef BAUD_GEN_FRAC_EN
            acc_q      <= acc_d;
            act_frac_q <= act_frac_d;
            sh_frac_q  <= sh_frac_d;
`endif
        end
    end

    assign os_tick     = os_tick_q;
    assign bit_tick    = bit_tick_q;
    assign mid_tick    = mid_tick_q;
    assign div_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed timing vectors plus randomized stimulus against a tick-schedule model.
module tb_baud_gen_frac;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;
    localparam longint FDEN = 64'd1 << FRAC_W;
`ifdef BAUD_GEN_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, div_load, resync;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        os_tick, bit_tick, mid_tick, div_pending;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    baud_gen_frac #(.DIV_W(16), .FRAC_W(FRAC_W), .OSR(OSR), .DIV_RST(27), .FRAC_RST(2)) dut (
        .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick),
        .mid_tick(mid_tick), .div_pending(div_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each os period lasts eff(div) clocks plus one whenever the running
    // fractional total crosses a multiple of 2^FRAC_W; ticks are classified by their index.
    int     m_act_int, m_act_frac, m_sh_int, m_sh_frac, m_elapsed;
    bit     m_pend;
    longint m_ftot, m_nticks;
    bit     exp_os, exp_bit, exp_mid;

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_act_int = 27; m_act_frac = 2; m_sh_int = 27; m_sh_frac = 2;
        m_pend = 1'b0; m_elapsed = 0; m_ftot = 0; m_nticks = 0;
    endtask

    task automatic model_step();
        int len;
        bit apply;
        apply = 1'b0;
        exp_os = 1'b0; exp_bit = 1'b0; exp_mid = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (div_load) begin
            m_sh_int = int'(div_int); m_sh_frac = int'(div_frac); m_pend = 1'b1;
        end
        if (!en) begin
            apply = m_pend;
        end else if (resync) begin
            m_elapsed = 0; m_nticks = 0; m_ftot = 0; apply = m_pend;
        end else begin
            len = eff(m_act_int);
            if (FRAC_ON) len += int'((m_ftot + m_act_frac) / FDEN - m_ftot / FDEN);
            if (m_elapsed + 1 >= len) begin
                m_nticks++;
                exp_os  = 1'b1;
                exp_bit = (m_nticks % OSR == 0);
                exp_mid = (m_nticks % OSR == OSR / 2);
                m_ftot += m_act_frac;
                m_elapsed = 0;
                apply = m_pend && exp_bit;
            end else begin
                m_elapsed++;
            end
        end
        if (apply) begin
            m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_pend = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            check("cycle_model", {28'd0, os_tick, bit_tick, mid_tick, div_pending},
                  {28'd0, exp_os, exp_bit, exp_mid, m_pend});
        end
    end

    task automatic wait_sig(input int which, input int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((which == 0 && os_tick) || (which == 1 && bit_tick) || (which == 2 && mid_tick)) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_resync(output int t0);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        t0 = cyc;
    endtask

    task automatic load(input int di, input int df);
        div_int = 16'(di); div_frac = 4'(df); div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    typedef struct {
        int di;
        int df;
        int mid_f;
        int bit_f;
        int mid_i;
        int bit_i;
    } vec_t;

    vec_t tbl[6];
    int t0, t1, t2, t3;

    initial begin
        tbl[0] = '{27, 2, 217, 434, 216, 432};
        tbl[1] = '{10, 0,  80, 160,  80, 160};
        tbl[2] = '{ 1, 0,  16,  32,  16,  32};
        tbl[3] = '{ 0, 5,  18,  37,  16,  32};
        tbl[4] = '{ 4, 8,  36,  72,  32,  64};
        tbl[5] = '{ 3, 15, 31,  63,  24,  48};

        rst = 1'b1; en = 1'b0; resync = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {28'd0, os_tick, bit_tick, mid_tick, div_pending}, 32'd0);

        // Defaults after reset: first os tick after 27 clocks, mid after 8 periods, bit after 16.
        t0 = cyc; rst = 1'b0; en = 1'b1;
        wait_sig(0, 100, t1);  check("first_os", t1 - t0, 27);
        wait_sig(2, 600, t1);  check("first_mid", t1 - t0, FRAC_ON ? 217 : 216);
        wait_sig(1, 600, t2);  check("first_bit", t2 - t0, FRAC_ON ? 434 : 432);
        wait_sig(1, 600, t3);  check("second_bit", t3 - t2, FRAC_ON ? 434 : 432);

        foreach (tbl[i]) begin
            pulse_resync(t0);
            load(tbl[i].di, tbl[i].df);
            check("tbl_pend_set", div_pending, 1);
            pulse_resync(t0);
            check("tbl_pend_clr", div_pending, 0);
            wait_sig(2, 2000, t1); check("tbl_mid", t1 - t0, FRAC_ON ? tbl[i].mid_f : tbl[i].mid_i);
            wait_sig(1, 2000, t2); check("tbl_bit", t2 - t0, FRAC_ON ? tbl[i].bit_f : tbl[i].bit_i);
            wait_sig(1, 2000, t3); check("tbl_bit2", t3 - t2, FRAC_ON ? tbl[i].bit_f : tbl[i].bit_i);
        end

        // Load without resync: held until the next bit boundary, then governs the very next period.
        pulse_resync(t0);
        repeat (3) @(negedge clk);
        load(10, 0);
        check("load_pending", div_pending, 1);
        wait_sig(1, 200, t1);
        check("load_applied", div_pending, 0);
        wait_sig(0, 100, t2);  check("post_apply_os1", t2 - t1, 10);
        wait_sig(0, 100, t3);  check("post_apply_os2", t3 - t2, 10);

        // Freezing for 50 clocks shifts the next tick by exactly 50.
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (50) @(negedge clk);
        en = 1'b1;
        wait_sig(0, 200, t1);  check("en_gap_os", t1 - t3, 60);

        // Resync at os count 9, mid-period.
        pulse_resync(t0);
        for (int k = 0; k < 9; k++) wait_sig(0, 100, t1);
        repeat (4) @(negedge clk);
        pulse_resync(t0);
        check("resync_quiet", {29'd0, os_tick, bit_tick, mid_tick}, 32'd0);
        wait_sig(2, 300, t1);  check("resync_mid", t1 - t0, 80);
        wait_sig(1, 300, t2);  check("resync_bit", t2 - t0, 160);

        // Load while frozen applies immediately.
        en = 1'b0;
        load(6, 0);
        check("en0_apply", div_pending, 0);
        en = 1'b1;
        pulse_resync(t0);
        wait_sig(0, 100, t1);  check("en0_period", t1 - t0, 6);

        // Back-to-back loads: last value wins.
        load(7, 0);
        load(9, 0);
        pulse_resync(t0);
        check("b2b_pend", div_pending, 0);
        wait_sig(0, 100, t1);  check("b2b_os1", t1 - t0, 9);
        wait_sig(0, 100, t2);  check("b2b_os2", t2 - t1, 9);

        // Reset mid-operation restores defaults.
        load(5, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", {28'd0, os_tick, bit_tick, mid_tick, div_pending}, 32'd0);
        t0 = cyc; rst = 1'b0;
        wait_sig(0, 100, t1);  check("midrst_os", t1 - t0, 27);

        // Randomized traffic, checked every cycle by the model.
        for (int n = 0; n < 6000; n++) begin
            en       = ($urandom_range(0, 9) != 0);
            div_load = ($urandom_range(0, 39) == 0);
            div_int  = 16'($urandom_range(0, 12));
            div_frac = 4'($urandom_range(0, 15));
            resync   = ($urandom_range(0, 149) == 0);
            rst      = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; en = 1'b0; div_load = 1'b0; resync = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
